sync_fifo: RTL and testbench

//  Parametrised single-clock FIFO: next generation of the 8x8 byte buffer between
//  the UART receiver and the indicator/display logic. Generalises width and depth;

---
 rtl/sync_fifo_pkg.sv | 32 +++
 rtl/sync_fifo_if.sv | 58 +++++
 rtl/sync_fifo_mem.sv | 27 ++
 rtl/sync_fifo.sv | 138 +++++++++++++
 tb/tb_sync_fifo.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants, operation encoding and width helper for the sync_fifo family.
// Used by the UART receive buffer and indicator FIFOs.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_DEPTH        = 16;
    localparam int DEFAULT_AF_THRESHOLD = 14;
    localparam int DEFAULT_AE_THRESHOLD = 2;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifoOp_e;

    function automatic int ptrWidth(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic fifoOp_e decodeOp(input logic wrOk, input logic rdOk);
        fifoOp_e op;
        case ({wrOk, rdOk})
            2'b01:   op = OP_READ;
            2'b10:   op = OP_WRITE;
            2'b11:   op = OP_BOTH;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake/status bundle for sync_fifo: the FIFO sits on the slave modport,
// its producer/consumer on the master modport.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
);

    localparam int PTR_W = ptrWidth(DEPTH);

    logic                  flush;
    logic                  write;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read;
    logic                  clear_errors;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [PTR_W:0]        level;
    logic                  overflow;
    logic                  underflow;

    modport slave (
        input  flush,
        input  write,
        input  data_in,
        input  read,
        input  clear_errors,
        output data_out,
        output empty,
        output full,
        output almost_empty,
        output almost_full,
        output level,
        output overflow,
        output underflow
    );

    modport master (
        output flush,
        output write,
        output data_in,
        output read,
        output clear_errors,
        input  data_out,
        input  empty,
        input  full,
        input  almost_empty,
        input  almost_full,
        input  level,
        input  overflow,
        input  underflow
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one synchronous write port and one asynchronous
// read port, so the head entry is visible without a read-data register.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clock,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset or cleared on flush.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock show-ahead FIFO with guarded read/write, fill level,
// almost flags and flush. Define SYNC_FIFO_ERR_EN for sticky overflow/underflow.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int AF_THRESHOLD = DEFAULT_AF_THRESHOLD,
    parameter int AE_THRESHOLD = DEFAULT_AE_THRESHOLD
) (
    input logic        clock,
    input logic        reset,
    sync_fifo_if.slave bus
);

    localparam int             PTR_W  = ptrWidth(DEPTH);
    localparam logic [PTR_W:0] AF_LVL = (PTR_W+1)'(AF_THRESHOLD);
    localparam logic [PTR_W:0] AE_LVL = (PTR_W+1)'(AE_THRESHOLD);

    logic [PTR_W:0] wrPtr_q, wrPtr_d;
    logic [PTR_W:0] rdPtr_q, rdPtr_d;
    logic [PTR_W:0] level_q, level_d;
    logic           emptyS;
    logic           fullS;
    logic           rdOk;
    logic           wrOk;
    logic           memWe;
    fifoOp_e        op;

    // Same index with differing wrap bits means the writer is a full lap ahead.
    assign emptyS = (wrPtr_q == rdPtr_q);
    assign fullS  = (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]) &&
                    (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]);

    assign rdOk  = bus.read & ~emptyS;
    assign wrOk  = bus.write & (~fullS | rdOk);
    assign op    = decodeOp(wrOk, rdOk);
    assign memWe = wrOk & ~bus.flush;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (bus.flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
        end else begin
            case (op)
                OP_WRITE: begin
                    wrPtr_d = wrPtr_q + 1'b1;
                    level_d = level_q + 1'b1;
                end
                OP_READ: begin
                    rdPtr_d = rdPtr_q + 1'b1;
                    level_d = level_q - 1'b1;
                end
                OP_BOTH: begin
                    wrPtr_d = wrPtr_q + 1'b1;
                    rdPtr_d = rdPtr_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clock   (clock),
        .we_i    (memWe),
        .waddr_i (wrPtr_q[PTR_W-1:0]),
        .wdata_i (bus.data_in),
        .raddr_i (rdPtr_q[PTR_W-1:0]),
        .rdata_o (bus.data_out)
    );

    assign bus.empty        = emptyS;
    assign bus.full         = fullS;
    assign bus.level        = level_q;
    assign bus.almost_empty = (level_q <= AE_LVL);
    assign bus.almost_full  = (level_q >= AF_LVL);

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error in the same cycle as clear_errors wins over the clear.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.clear_errors) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (bus.write & ~wrOk & ~bus.flush) begin
            overflow_d = 1'b1;
        end
        if (bus.read & emptyS & ~bus.flush) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    logic unusedClearErrors;
    assign unusedClearErrors = bus.clear_errors;
    assign bus.overflow      = 1'b0;
    assign bus.underflow     = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model plus a
// scoreboard of expected output words popped by a negedge monitor.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) fifoBus ();

    sync_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AF_THRESHOLD (AF),
        .AE_THRESHOLD (AE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (fifoBus)
    );

    always #5 clock = ~clock;

    int       compared   = 0;
    int       mismatched = 0;
    logic [7:0] refQ[$];
    logic [7:0] sbQ[$];
    bit       refOvf  = 1'b0;
    bit       refUnf  = 1'b0;
    bit       started = 1'b0;

    // Reference model: the FIFO as a plain queue of words, updated on each edge.
    always @(posedge clock) begin : model
        int cnt;
        bit rdOk;
        bit wrOk;
        cnt  = refQ.size();
        rdOk = fifoBus.read && (cnt > 0);
        wrOk = fifoBus.write && ((cnt < DEPTH) || rdOk);
        if (reset) begin
            refQ.delete();
            sbQ.delete();
            refOvf  = 1'b0;
            refUnf  = 1'b0;
            started = 1'b1;
        end else if (started) begin
`ifdef SYNC_FIFO_ERR_EN
            if (fifoBus.clear_errors) begin
                refOvf = 1'b0;
                refUnf = 1'b0;
            end
            if (fifoBus.write && !wrOk && !fifoBus.flush) refOvf = 1'b1;
            if (fifoBus.read && (cnt == 0) && !fifoBus.flush) refUnf = 1'b1;
`endif
            if (fifoBus.flush) begin
                refQ.delete();
                sbQ.delete();
            end else begin
                if (rdOk) void'(refQ.pop_front());
                if (wrOk) begin
                    refQ.push_back(fifoBus.data_in);
                    sbQ.push_back(fifoBus.data_in);
                end
            end
        end
    end

    task automatic compareField(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        int lvl;
        lvl = refQ.size();
        compareField("level", int'(fifoBus.level), lvl);
        compareField("empty", int'(fifoBus.empty), int'(lvl == 0));
        compareField("full", int'(fifoBus.full), int'(lvl == DEPTH));
        compareField("almost_empty", int'(fifoBus.almost_empty), int'(lvl <= AE));
        compareField("almost_full", int'(fifoBus.almost_full), int'(lvl >= AF));
        compareField("overflow", int'(fifoBus.overflow), int'(refOvf));
        compareField("underflow", int'(fifoBus.underflow), int'(refUnf));
        if (lvl > 0) compareField("head", int'(fifoBus.data_out), int'(refQ[0]));
        // Scoreboard: every word the DUT pops must be the next one queued.
        if (!reset && !fifoBus.flush && fifoBus.read && !fifoBus.empty) begin
            if (sbQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL pop_unexpected at %0t: got 0x%0h, expected no pop",
                         $time, fifoBus.data_out);
            end else begin
                compareField("pop_data", int'(fifoBus.data_out), int'(sbQ.pop_front()));
            end
        end
    endtask

    always @(negedge clock) begin
        if (started) checkOutput();
    end

    task automatic applyStimulus(input bit w, input logic [7:0] d, input bit r,
                                 input bit f = 1'b0, input bit c = 1'b0,
                                 input bit rst = 1'b0);
        fifoBus.write        = w;
        fifoBus.data_in      = d;
        fifoBus.read         = r;
        fifoBus.flush        = f;
        fifoBus.clear_errors = c;
        reset                = rst;
        @(posedge clock);
        #1;
    endtask

    task automatic fillWords(input int n, input int base);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 8'(base + i), 1'b0);
    endtask

    task automatic drainWords(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        fifoBus.write        = 1'b0;
        fifoBus.data_in      = '0;
        fifoBus.read         = 1'b0;
        fifoBus.flush        = 1'b0;
        fifoBus.clear_errors = 1'b0;
        reset                = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Fill 0x01..0x10 to full, then drain in order.
        fillWords(DEPTH, 1);
        drainWords(DEPTH);

        // Write to a full FIFO, then clear the error.
        fillWords(DEPTH, 8'h20);
        applyStimulus(1'b1, 8'hAA, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Read+write on empty, then read+write on full.
        drainWords(DEPTH);
        applyStimulus(1'b1, 8'h55, 1'b1);
        fillWords(DEPTH - 1, 8'h60);
        applyStimulus(1'b1, 8'h77, 1'b1);
        drainWords(DEPTH);

        // Pointer wrap at a steady level of 3.
        fillWords(3, 8'h80);
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'($urandom_range(0, 255)), 1'b1);
        drainWords(3);

        // Flush with a concurrent write, then reuse.
        fillWords(9, 8'hC0);
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h3C, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);

        // Reset mid-stream, then error set and clear in the same cycle.
        fillWords(5, 8'hD0);
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
        fillWords(DEPTH, 8'h40);
        applyStimulus(1'b1, 8'hEE, 1'b0);
        applyStimulus(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        drainWords(DEPTH + 1);
        applyStimulus(1'b0, 8'h00, 1'b1);

        // Randomised traffic, alternating write-heavy and read-heavy phases.
        for (int i = 0; i < 900; i++) begin
            bit writeHeavy;
            int rw;
            writeHeavy = ((i / 60) % 2) == 0;
            rw         = $urandom_range(0, 99);
            applyStimulus(writeHeavy ? (rw < 75) : (rw < 30),
                          8'($urandom_range(0, 255)),
                          writeHeavy ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 75),
                          $urandom_range(0, 79) == 0,
                          $urandom_range(0, 24) == 0,
                          $urandom_range(0, 299) == 0);
        end

        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
